// File: rtl/xm23_pkg.sv
// ---------------------------------------------------------------------------
// xm23_pkg
// Shared definitions for the XM23 memory responder.
//   CR_E / CR_RW / CR_WB : bit positions of the CPU control-register fields
//   BYTE / WORD          : encodings of the CR word/byte select bit
//   resp_state_t         : responder FSM states
// ---------------------------------------------------------------------------
package xm23_pkg;

  localparam int CR_E  = 0;
  localparam int CR_RW = 1;
  localparam int CR_WB = 2;

  localparam logic BYTE = 1'b1;
  localparam logic WORD = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE,
    HOLD
  } resp_state_t;

endpackage

// File: rtl/xm23_mem_bank.sv
// ---------------------------------------------------------------------------
// xm23_mem_bank
// 8-bit synchronous single-port RAM holding one byte lane (even or odd).
//   clk   : clock, all accesses on the rising edge
//   addr  : bank index (byte address without bit 0)
//   wdata : byte to store when we=1
//   we    : write enable
//   rdata : registered read data (read-before-write)
// Contents are not reset.
// ---------------------------------------------------------------------------
module xm23_mem_bank #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-2:0] addr,
  input  logic [7:0]            wdata,
  input  logic                  we,
  output logic [7:0]            rdata
);

  logic [7:0] r_mem [0:(1 << (ADDR_WIDTH-1))-1];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/xm23_mem_responder.sv
// ---------------------------------------------------------------------------
// xm23_mem_responder
// Memory-side responder for the XM23 CR/MAR/MDR memory protocol. Accepts one
// byte or word request at a time, stalls WAIT_STATES cycles, performs the
// access on two 8-bit banks (even/odd) and pulses done for one cycle.
//   Clock    : system clock
//   Reset_n  : asynchronous active-low reset
//   cr_e     : request enable, held until done is seen
//   cr_rw    : 1 = write, 0 = read
//   cr_wb    : 1 = byte, 0 = word
//   mar      : byte address
//   mdr_out  : write data from the MDR
//   mdr_in   : read data toward the MDR (changes only on read completion)
//   busy     : request accepted and not yet completed
//   done     : one-cycle completion pulse
// ---------------------------------------------------------------------------
module xm23_mem_responder
  import xm23_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  cr_e,
  input  logic                  cr_rw,
  input  logic                  cr_wb,
  input  logic [ADDR_WIDTH-1:0] mar,
  input  logic [15:0]           mdr_out,
  output logic [15:0]           mdr_in,
  output logic                  busy,
  output logic                  done
);

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  resp_state_t           r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_wdata;
  logic                  r_rw;
  logic                  r_wb;

  logic                  w_access;
  logic                  w_we_even;
  logic                  w_we_odd;
  logic [7:0]            w_wd_odd;
  logic [7:0]            w_rd_even;
  logic [7:0]            w_rd_odd;
  logic [15:0]           w_rdata;

  // Request capture: only an IDLE accept updates the latched request, so
  // bus changes while busy or in HOLD never reach the banks.
  always_ff @(posedge Clock) begin
    if (r_state == IDLE && cr_e) begin
      r_addr  <= mar;
      r_wdata <= mdr_out;
      r_rw    <= cr_rw;
      r_wb    <= cr_wb;
    end
  end

  // Bank strobes come straight from the ACCESS state, so an asynchronous
  // reset before the ACCESS edge cancels a pending write.
  assign w_access  = (r_state == ACCESS);
  assign w_we_even = w_access && r_rw && ((r_wb == WORD) || !r_addr[0]);
  assign w_we_odd  = w_access && r_rw && ((r_wb == WORD) ||  r_addr[0]);
  assign w_wd_odd  = (r_wb == BYTE) ? r_wdata[7:0] : r_wdata[15:8];

  xm23_mem_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank_even (
    .clk   (Clock),
    .addr  (r_addr[ADDR_WIDTH-1:1]),
    .wdata (r_wdata[7:0]),
    .we    (w_we_even),
    .rdata (w_rd_even)
  );

  xm23_mem_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank_odd (
    .clk   (Clock),
    .addr  (r_addr[ADDR_WIDTH-1:1]),
    .wdata (w_wd_odd),
    .we    (w_we_odd),
    .rdata (w_rd_odd)
  );

  // Byte reads are zero-extended; word reads ignore address bit 0.
  assign w_rdata = (r_wb == BYTE) ? {8'h00, (r_addr[0] ? w_rd_odd : w_rd_even)}
                                  : {w_rd_odd, w_rd_even};

  // Control FSM. done/busy/mdr_in are registered as the FSM leaves DONE, so
  // done is visible (2 + WAIT_STATES) edges after the accept edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      mdr_in  <= 16'h0000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cr_e) begin
            busy <= 1'b1;
            if (WAIT_STATES > 0) begin
              r_cnt   <= WS_LOAD;
              r_state <= WAIT;
            end else begin
              r_state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ACCESS: r_state <= DONE;
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (!r_rw) begin
            mdr_in <= w_rdata;
          end
          r_state <= HOLD;
        end
        // Wait for the CPU to release cr_e so a held request is not re-run.
        HOLD: begin
          if (!cr_e) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xm23_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_xm23_mem_responder
// Two responders share a clock and reset: index 0 has no wait states, index 1
// has three. Directed requests push their expected mdr_in into a per-DUT
// queue; a monitor pops and compares whenever a DUT pulses done.
// ---------------------------------------------------------------------------
module tb_xm23_mem_responder;
  import xm23_pkg::*;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic [1:0]        cr_e, cr_rw, cr_wb;
  logic [1:0][15:0]  mar, mdr_out, mdr_in;
  logic [1:0]        busy, done;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  xm23_mem_responder #(.ADDR_WIDTH(16), .WAIT_STATES(0)) dut0 (
    .Clock(Clock), .Reset_n(Reset_n), .cr_e(cr_e[0]), .cr_rw(cr_rw[0]),
    .cr_wb(cr_wb[0]), .mar(mar[0]), .mdr_out(mdr_out[0]), .mdr_in(mdr_in[0]),
    .busy(busy[0]), .done(done[0])
  );

  xm23_mem_responder #(.ADDR_WIDTH(16), .WAIT_STATES(3)) dut1 (
    .Clock(Clock), .Reset_n(Reset_n), .cr_e(cr_e[1]), .cr_rw(cr_rw[1]),
    .cr_wb(cr_wb[1]), .mar(mar[1]), .mdr_out(mdr_out[1]), .mdr_in(mdr_in[1]),
    .busy(busy[1]), .done(done[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (done[0]) begin
      if (q0.size() == 0) chk("unexpected_done0", 32'd1, 32'd0);
      else                chk("mdr_in0", 32'(mdr_in[0]), 32'(q0.pop_front()));
    end
    if (done[1]) begin
      if (q1.size() == 0) chk("unexpected_done1", 32'd1, 32'd0);
      else                chk("mdr_in1", 32'(mdr_in[1]), 32'(q1.pop_front()));
    end
  end

  // One request on DUT k. exp_md is mdr_in expected at done (held value for
  // writes). hold = extra cycles cr_e stays high after done; mutate scrambles
  // the request inputs after accept; drop_early releases cr_e after accept.
  task automatic access(input int k, input logic rw, input logic wb,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_md, input int hold,
                        input bit mutate, input bit drop_early);
    int lat, bcnt, ws;
    ws = (k == 1) ? 3 : 0;
    @(negedge Clock);
    cr_rw[k] = rw; cr_wb[k] = wb; mar[k] = addr; mdr_out[k] = wd; cr_e[k] = 1'b1;
    if (k == 0) q0.push_back(exp_md); else q1.push_back(exp_md);
    @(posedge Clock);
    lat = 0; bcnt = 0;
    do begin
      @(negedge Clock);
      lat++;
      if (busy[k]) bcnt++;
      if (lat == 1) begin
        if (mutate) begin
          mar[k] = ~addr; mdr_out[k] = ~wd; cr_rw[k] = ~rw; cr_wb[k] = ~wb;
        end
        if (drop_early) cr_e[k] = 1'b0;
      end
    end while (!done[k] && lat < 40);
    chk($sformatf("latency%0d", k), 32'(lat), 32'(3 + ws));
    chk($sformatf("busy_cycles%0d", k), 32'(bcnt), 32'(2 + ws));
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock);
      chk($sformatf("hold_busy%0d", k), 32'(busy[k]), 32'd0);
      chk($sformatf("hold_done%0d", k), 32'(done[k]), 32'd0);
    end
    cr_e[k] = 1'b0;
    @(negedge Clock);
    chk($sformatf("post_done%0d", k), 32'(done[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    cr_e = '0; cr_rw = '0; cr_wb = '0; mar = '0; mdr_out = '0;
    repeat (3) @(negedge Clock);
    chk("rst_mdr_in0", 32'(mdr_in[0]), 32'd0);
    chk("rst_busy0",   32'(busy[0]),   32'd0);
    chk("rst_done0",   32'(done[0]),   32'd0);
    chk("rst_mdr_in1", 32'(mdr_in[1]), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clock);

    // No wait states: word, byte, alignment and top-of-memory accesses.
    access(0, 1'b1, WORD, 16'h0010, 16'hBEEF, 16'h0000, 0, 0, 0);
    access(0, 1'b0, WORD, 16'h0010, 16'h0000, 16'hBEEF, 2, 0, 0);
    access(0, 1'b1, BYTE, 16'h0011, 16'h775A, 16'hBEEF, 0, 0, 0);
    access(0, 1'b0, BYTE, 16'h0011, 16'h0000, 16'h005A, 0, 0, 0);
    access(0, 1'b0, WORD, 16'h0010, 16'h0000, 16'h5AEF, 0, 0, 0);
    access(0, 1'b0, WORD, 16'h0011, 16'h0000, 16'h5AEF, 0, 0, 0);
    access(0, 1'b0, BYTE, 16'h0010, 16'h0000, 16'h00EF, 0, 0, 0);
    access(0, 1'b1, BYTE, 16'h0010, 16'h9933, 16'h00EF, 0, 0, 0);
    access(0, 1'b0, WORD, 16'h0010, 16'h0000, 16'h5A33, 0, 0, 0);
    access(0, 1'b1, WORD, 16'hFFFF, 16'hA5C3, 16'h5A33, 0, 0, 0);
    access(0, 1'b0, BYTE, 16'hFFFE, 16'h0000, 16'h00C3, 0, 0, 0);
    access(0, 1'b0, BYTE, 16'hFFFF, 16'h0000, 16'h00A5, 0, 0, 0);
    access(0, 1'b1, WORD, 16'h0040, 16'h1111, 16'h00A5, 0, 1, 0);
    access(0, 1'b0, WORD, 16'h0040, 16'h0000, 16'h1111, 0, 0, 0);

    // Three wait states: held request, then reset during WAIT of a write.
    access(1, 1'b1, WORD, 16'h0020, 16'hCAFE, 16'h0000, 0, 1, 0);
    access(1, 1'b0, WORD, 16'h0020, 16'h0000, 16'hCAFE, 5, 0, 0);

    @(negedge Clock);
    cr_rw[1] = 1'b1; cr_wb[1] = WORD; mar[1] = 16'h0020; mdr_out[1] = 16'h1234;
    cr_e[1] = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    chk("pre_rst_busy1", 32'(busy[1]), 32'd1);
    Reset_n = 1'b0;
    cr_e[1] = 1'b0;
    #1;
    chk("rst_async_busy1",   32'(busy[1]),   32'd0);
    chk("rst_async_done1",   32'(done[1]),   32'd0);
    chk("rst_async_mdr_in1", 32'(mdr_in[1]), 32'd0);
    chk("rst_async_mdr_in0", 32'(mdr_in[0]), 32'd0);
    repeat (2) @(negedge Clock);
    chk("rst_hold_busy1", 32'(busy[1]), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clock);

    access(1, 1'b0, WORD, 16'h0020, 16'h0000, 16'hCAFE, 0, 0, 0);
    access(1, 1'b0, BYTE, 16'h0021, 16'h0000, 16'h00CA, 0, 0, 1);
    access(1, 1'b0, WORD, 16'h0021, 16'h0000, 16'hCAFE, 0, 0, 0);

    repeat (3) @(negedge Clock);
    chk("queue0_empty", 32'(q0.size()), 32'd0);
    chk("queue1_empty", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
